// File: rtl/round_pkg.sv
// Shared types and constants for the round sequencer and its LFSR.
package round_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      GEN        = 3'd1,
      WAIT_GUESS = 3'd2,
      CHECK      = 3'd3,
      WIN        = 3'd4,
      LOSE       = 3'd5
   } state_e;

   localparam logic [15:0] LFSR_MASK    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // One step of the right-shifting Galois LFSR (maximal length, never hits 0).
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/round_sequencer_lfsr16.sv
// Free-running 16-bit Galois LFSR; reusable random source for the game logic.
module lfsr16
   import round_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        Clk,
   input  logic        Rst,
   output logic [15:0] Lfsr
);

   // An all-zero seed would lock the register, so it falls back to the default.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

   logic [15:0] lfsr_q;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) lfsr_q <= SEED_EFF;
      else      lfsr_q <= lfsr_step(lfsr_q);
   end

   assign Lfsr = lfsr_q;

endmodule

// File: rtl/round_sequencer.sv
// Game-flow controller: rolls three random nibbles, captures the guess, scores it.
module round_sequencer
   import round_pkg::*;
#(
   parameter int          LIVES_INIT = 3,
   parameter int          WIN_SCORE  = 5,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic        Submit,
   input  logic [5:0]  Guess,
   input  logic        Compare,
   output logic [3:0]  Rng1,
   output logic [3:0]  Rng2,
   output logic [3:0]  Rng3,
   output logic [5:0]  LR,
   output logic [1:0]  Lives,
   output logic [3:0]  Score,
   output logic        Win,
   output logic        Lose,
   output logic        Busy,
   output logic [2:0]  State_dbg,
   output logic [15:0] Lfsr_dbg
);

   state_e      state_q, state_d;
   logic [3:0]  rng1_q, rng1_d, rng2_q, rng2_d, rng3_q, rng3_d;
   logic [5:0]  lr_q, lr_d;
   logic [1:0]  lives_q, lives_d;
   logic [3:0]  score_q, score_d;
   logic        start_hist_q, submit_hist_q;
   logic        start_ev, submit_ev;
   logic [15:0] lfsr_val;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .Clk  (Clk),
      .Rst  (Rst),
      .Lfsr (lfsr_val)
   );

   assign start_ev  = Start  & ~start_hist_q;
   assign submit_ev = Submit & ~submit_hist_q;

   // History regs reset high so a button already held at release is not an event.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q       <= IDLE;
         rng1_q        <= '0;
         rng2_q        <= '0;
         rng3_q        <= '0;
         lr_q          <= '0;
         lives_q       <= '0;
         score_q       <= '0;
         start_hist_q  <= 1'b1;
         submit_hist_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         rng1_q        <= rng1_d;
         rng2_q        <= rng2_d;
         rng3_q        <= rng3_d;
         lr_q          <= lr_d;
         lives_q       <= lives_d;
         score_q       <= score_d;
         start_hist_q  <= Start;
         submit_hist_q <= Submit;
      end
   end

   always_comb begin
      state_d = state_q;
      rng1_d  = rng1_q;
      rng2_d  = rng2_q;
      rng3_d  = rng3_q;
      lr_d    = lr_q;
      lives_d = lives_q;
      score_d = score_q;

      if (start_ev) begin
         lives_d = 2'(LIVES_INIT);
         score_d = '0;
         lr_d    = '0;
         state_d = GEN;
      end else begin
         case (state_q)
            GEN: begin
               rng1_d  = lfsr_val[3:0];
               rng2_d  = lfsr_val[7:4];
               rng3_d  = lfsr_val[11:8];
               state_d = WAIT_GUESS;
            end
            WAIT_GUESS: begin
               if (submit_ev) begin
                  lr_d    = Guess;
                  state_d = CHECK;
               end
            end
            // Compare is driven from the registered Rng/LR, so it is settled here.
            CHECK: begin
               if (!Compare) begin
                  score_d = score_q + 4'd1;
                  state_d = (score_q + 4'd1 == 4'(WIN_SCORE)) ? WIN : GEN;
               end else begin
                  lives_d = lives_q - 2'd1;
                  state_d = (lives_q == 2'd1) ? LOSE : WAIT_GUESS;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   assign Rng1      = rng1_q;
   assign Rng2      = rng2_q;
   assign Rng3      = rng3_q;
   assign LR        = lr_q;
   assign Lives     = lives_q;
   assign Score     = score_q;
   assign Win       = (state_q == WIN);
   assign Lose      = (state_q == LOSE);
   assign Busy      = (state_q == GEN) || (state_q == CHECK);
   assign State_dbg = state_q;
   assign Lfsr_dbg  = lfsr_val;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a game-level reference model.
module tb_round_sequencer;
   import round_pkg::*;

   localparam int LIVES = 3;
   localparam int WINS  = 2;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start = 1'b0, Submit = 1'b0, Compare = 1'b0;
   logic [5:0]  Guess = 6'd0;
   logic [3:0]  Rng1, Rng2, Rng3, Score;
   logic [5:0]  LR;
   logic [1:0]  Lives;
   logic        Win, Lose, Busy;
   logic [2:0]  State_dbg;
   logic [15:0] Lfsr_dbg;

   round_sequencer #(.LIVES_INIT(LIVES), .WIN_SCORE(WINS), .LFSR_SEED(16'hACE1)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Submit(Submit), .Guess(Guess),
      .Compare(Compare), .Rng1(Rng1), .Rng2(Rng2), .Rng3(Rng3), .LR(LR),
      .Lives(Lives), .Score(Score), .Win(Win), .Lose(Lose), .Busy(Busy),
      .State_dbg(State_dbg), .Lfsr_dbg(Lfsr_dbg)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: game rules in plain terms ----------------
   typedef enum {P_IDLE, P_ROLL, P_ASK, P_JUDGE, P_WON, P_LOST} phase_t;
   phase_t      m_phase;
   int          m_lives, m_score;
   logic [3:0]  m_rng [3];
   logic [5:0]  m_lr;
   logic [15:0] m_lfsr;
   bit          m_start_prev, m_submit_prev, m_sev, m_bev;

   function automatic logic [15:0] model_next(input logic [15:0] v);
      int x;
      x = int'(v) / 2;
      if (v % 2 == 1) x = x ^ 'hB400;
      return 16'(x);
   endfunction

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         m_phase = P_IDLE; m_lives = 0; m_score = 0; m_lr = 0;
         m_rng[0] = 0; m_rng[1] = 0; m_rng[2] = 0;
         m_lfsr = 16'hACE1; m_start_prev = 1; m_submit_prev = 1;
      end else begin
         m_sev = Start && !m_start_prev;
         m_bev = Submit && !m_submit_prev;
         m_start_prev = Start;
         m_submit_prev = Submit;
         if (m_sev) begin
            m_lives = LIVES; m_score = 0; m_lr = 0; m_phase = P_ROLL;
         end else begin
            case (m_phase)
               P_ROLL: begin
                  m_rng[0] = 4'(m_lfsr % 16);
                  m_rng[1] = 4'((m_lfsr / 16) % 16);
                  m_rng[2] = 4'((m_lfsr / 256) % 16);
                  m_phase = P_ASK;
               end
               P_ASK: if (m_bev) begin m_lr = Guess; m_phase = P_JUDGE; end
               P_JUDGE: begin
                  if (Compare == 1'b0) begin
                     m_score++;
                     m_phase = (m_score == WINS) ? P_WON : P_ROLL;
                  end else begin
                     m_lives--;
                     m_phase = (m_lives == 0) ? P_LOST : P_ASK;
                  end
               end
               default: ;
            endcase
         end
         m_lfsr = model_next(m_lfsr);
      end
   end

   function automatic logic [31:0] dut_vec();
      return {5'd0, Rng1, Rng2, Rng3, LR, Lives, Score, Win, Lose, Busy};
   endfunction

   function automatic logic [31:0] model_vec();
      return {5'd0, m_rng[0], m_rng[1], m_rng[2], m_lr, 2'(m_lives), 4'(m_score),
              m_phase == P_WON, m_phase == P_LOST, (m_phase == P_ROLL) || (m_phase == P_JUDGE)};
   endfunction

   always @(negedge Clk) begin
      if (chk_on) begin
         chk("outputs_vs_model", dut_vec(), model_vec());
         chk("lfsr_vs_model", 32'(Lfsr_dbg), 32'(m_lfsr));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic start_game();
      Start = 1'b0; tick(1);
      Start = 1'b1; tick(1);
      Start = 1'b0; tick(1);
   endtask

   task automatic submit(input logic [5:0] g, input logic cmp);
      Submit = 1'b0; tick(1);
      Guess = g; Compare = cmp; Submit = 1'b1; tick(1);
      Submit = 1'b0; tick(2);
   endtask

   initial begin
      logic [15:0] v;
      int zero_hits, early;

      // Model pins: hand-stepped LFSR values and full period.
      chk("model_step1", 32'(model_next(16'hACE1)), 32'h0000E270);
      chk("model_step2", 32'(model_next(16'hE270)), 32'h00007138);
      chk("model_step3", 32'(model_next(16'h7138)), 32'h0000389C);
      v = 16'hACE1; zero_hits = 0; early = 0;
      for (int i = 1; i <= 65535; i++) begin
         v = model_next(v);
         if (v == 16'h0) zero_hits++;
         if (v == 16'hACE1 && i < 65535) early++;
      end
      chk("model_period_end", 32'(v), 32'h0000ACE1);
      chk("model_period_clean", 32'(zero_hits + early), 32'd0);

      #1 Rst = 1'b0;
      chk_on = 1'b1;
      tick(3);
      chk("reset_outputs", dut_vec(), 32'd0);
      chk("reset_state", 32'(State_dbg), 32'(IDLE));
      chk("reset_lfsr", 32'(Lfsr_dbg), 32'h0000ACE1);

      // Start held across release must not start a game; LFSR runs its full period.
      Start = 1'b1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("lfsr_first_step", 32'(Lfsr_dbg), 32'h0000E270);
      repeat (65534) @(posedge Clk);
      #1;
      chk("lfsr_period_return", 32'(Lfsr_dbg), 32'h0000ACE1);
      chk("no_spurious_start", 32'(Busy), 32'd0);
      chk("idle_after_release", 32'(State_dbg), 32'(IDLE));
      tick(1);

      // Win path.
      start_game();
      chk("win_lives_loaded", 32'(Lives), 32'd3);
      submit(6'h11, 1'b0);
      chk("win_score1", 32'(Score), 32'd1);
      submit(6'h22, 1'b0);
      chk("win_score2", 32'(Score), 32'd2);
      chk("win_flag", 32'(Win), 32'd1);
      chk("win_lives", 32'(Lives), 32'd3);

      // Lose path.
      start_game();
      submit(6'h05, 1'b1);
      chk("lose_lives2", 32'(Lives), 32'd2);
      submit(6'h06, 1'b1);
      chk("lose_lives1", 32'(Lives), 32'd1);
      submit(6'h07, 1'b1);
      chk("lose_lives0", 32'(Lives), 32'd0);
      chk("lose_flag", 32'(Lose), 32'd1);
      chk("lose_lr_held", 32'(LR), 32'h07);

      // Retry then correct.
      start_game();
      submit(6'h2B, 1'b1);
      chk("retry_lives", 32'(Lives), 32'd2);
      submit(6'h2C, 1'b0);
      chk("retry_score", 32'(Score), 32'd1);

      // Holding Submit gives one check only.
      Submit = 1'b0; tick(1);
      Compare = 1'b1; Guess = 6'h33; Submit = 1'b1;
      tick(10);
      Submit = 1'b0; tick(1);
      chk("hold_one_check", 32'(Lives), 32'd1);
      chk("hold_lr", 32'(LR), 32'h33);

      // Start and Submit together: Start wins, Submit ignored.
      Start = 1'b1; Submit = 1'b1; Guess = 6'h2A; tick(1);
      chk("both_lr_cleared", 32'(LR), 32'd0);
      chk("both_busy_gen", 32'(Busy), 32'd1);
      chk("both_lives", 32'(Lives), 32'd3);
      Start = 1'b0; Submit = 1'b0; tick(1);

      // Asynchronous reset in the middle of CHECK.
      tick(1);
      Guess = 6'h15; Compare = 1'b0; Submit = 1'b1; tick(1);
      chk("midcheck_lr", 32'(LR), 32'h15);
      #2 Rst = 1'b0;
      #1;
      chk("async_reset_outputs", dut_vec(), 32'd0);
      chk("async_reset_state", 32'(State_dbg), 32'(IDLE));
      Start = 1'b1; Submit = 1'b0;
      @(negedge Clk) Rst = 1'b1;
      tick(3);
      chk("release_no_start", 32'(Busy), 32'd0);
      Start = 1'b0; tick(1);

      // Submit in IDLE is ignored.
      Guess = 6'h3F; Submit = 1'b1; tick(2);
      Submit = 1'b0; tick(1);
      chk("idle_submit_lr", 32'(LR), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
